// File: rtl/serial_adder_if.sv
// Handshake/data bundle for serial_adder.
// The sub signal and its modport entries exist only when SERIAL_SUB_EN is defined.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

`ifdef SERIAL_SUB_EN
    modport master (
        output start, a, b, sub,
        input  busy, done, sum, carry_out
    );
    modport slave (
        input  start, a, b, sub,
        output busy, done, sum, carry_out
    );
`else
    modport master (
        output start, a, b,
        input  busy, done, sum, carry_out
    );
    modport slave (
        input  start, a, b,
        output busy, done, sum, carry_out
    );
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flop, LSB first.
// One operand bit is processed per clock; the result is published only on
// completion. Build option SERIAL_SUB_EN adds a sub request that computes
// a + ~b + 1 on the same datapath and reports the borrow on carry_out.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input logic          clk,
    input logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int unsigned   CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Holds the WIDTH-1 bits already produced; the last bit joins on the final edge.
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_wide;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             sub_op;
    logic             start_sub;
    logic             bit_sum;
    logic             bit_carry;

    // Subtract request as seen at the start handshake (constant 0 in add-only builds).
`ifdef SERIAL_SUB_EN
    assign start_sub = bus.sub;
`else
    assign start_sub = 1'b0;
`endif

    // Single full-adder cell on the current LSBs and the carry flop.
    always_comb begin
        bit_sum   = a_sh[0] ^ b_sh[0] ^ carry;
        bit_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    end

    // Result shifts right with the new bit entering at the MSB.
    assign res_wide = {bit_sum, res_sh};

    // Control FSM plus datapath registers; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            a_sh          <= '0;
            b_sh          <= '0;
            res_sh        <= '0;
            carry         <= 1'b0;
            cnt           <= '0;
            sub_op        <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.sum       <= '0;
            bus.carry_out <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                StIdle: begin
                    if (bus.start) begin
                        state    <= StShift;
                        a_sh     <= bus.a;
                        // Subtraction is a + ~b + 1: invert b, preset carry.
                        b_sh     <= start_sub ? ~bus.b : bus.b;
                        carry    <= start_sub;
                        sub_op   <= start_sub;
                        res_sh   <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                StShift: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= bit_carry;
                    res_sh <= res_wide[WIDTH-1:1];
                    if (cnt == LAST_BIT) begin
                        state         <= StDone;
                        cnt           <= '0;
                        bus.done      <= 1'b1;
                        bus.sum       <= res_wide;
                        // Borrow is the complement of the final carry in subtract mode.
                        bus.carry_out <= bit_carry ^ sub_op;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                StDone: begin
                    state    <= StIdle;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= StIdle;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
